// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// the address-split width helpers used by the top and the tag array.
package dmem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_COMPLETE = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        ACCESS   = ST_ACCESS,
        COMPLETE = ST_COMPLETE
    } dmem_state_e;

    // Line index occupies Addr[index_w:1] (bit 0 is the byte-in-word bit).
    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Everything above the index is tag.
    function automatic int tag_w(input int lines);
        return ADDR_W - $clog2(lines) - 1;
    endfunction

endpackage

// File: rtl/dmem_tag_array.sv
// Direct-mapped valid/tag/data store: combinational lookup, one write port
// shared by read fills and write-hit updates, valid bits cleared on rst.
module dmem_tag_array
    import dmem_pkg::*;
#(
    parameter  int LINES   = 16,
    localparam int INDEX_W = index_w(LINES),
    localparam int TAG_W   = tag_w(LINES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] lookup_index,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               hit,
    output logic [DATA_W-1:0]  hit_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    assign hit      = valid[lookup_index] && (tag_mem[lookup_index] == lookup_tag);
    assign hit_data = data_mem[lookup_index];

    // Valid bits: only state that needs clearing; a written line is always valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data responder: same-cycle read hits from a direct-mapped
// write-through cache, stalls for misses and writes served by backing memory.
// Build option: define DMEM_CACHE_EN to include the cache; without it every
// legal read goes to backing memory.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    dmem_state_e       state, state_nxt;
    logic              req, illegal, hit, start_access, ack_seen;
    logic [DATA_W-1:0] hit_data;
    logic [DATA_W-1:0] dout_q;

    assign req          = Rd | Wr;
    assign illegal      = req & ((Rd & Wr) | Addr[0]);
    assign start_access = (state == IDLE) && req && !illegal && !(Rd && hit);
    assign ack_seen     = (state == ACCESS) && mem_ack;

`ifdef DMEM_CACHE_EN
    localparam int INDEX_W = index_w(LINES);
    localparam int TAG_W   = tag_w(LINES);

    logic               arr_wr_en;
    logic [INDEX_W-1:0] arr_wr_index;
    logic [TAG_W-1:0]   arr_wr_tag;
    logic [DATA_W-1:0]  arr_wr_data;

    // Cache write port: write-hit update in the request cycle, or read fill
    // on the acked ACCESS cycle; never while reset is asserted.
    always_comb begin
        arr_wr_en    = 1'b0;
        arr_wr_index = Addr[INDEX_W:1];
        arr_wr_tag   = Addr[ADDR_W-1:INDEX_W+1];
        arr_wr_data  = DataIn;
        if (!rst) begin
            if (state == IDLE && Wr && !illegal && hit) begin
                arr_wr_en = 1'b1;
            end else if (ack_seen && mem_rd) begin
                arr_wr_en    = 1'b1;
                arr_wr_index = mem_addr[INDEX_W:1];
                arr_wr_tag   = mem_addr[ADDR_W-1:INDEX_W+1];
                arr_wr_data  = mem_rdata;
            end
        end
    end

    dmem_tag_array #(.LINES(LINES)) u_tag_array (
        .clk          (clk),
        .rst          (rst),
        .lookup_index (Addr[INDEX_W:1]),
        .lookup_tag   (Addr[ADDR_W-1:INDEX_W+1]),
        .hit          (hit),
        .hit_data     (hit_data),
        .wr_en        (arr_wr_en),
        .wr_index     (arr_wr_index),
        .wr_tag       (arr_wr_tag),
        .wr_data      (arr_wr_data)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // State, backing-memory request registers and the latched read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dout_q    <= '0;
        end else begin
            state <= state_nxt;
            if (start_access) begin
                mem_rd    <= Rd;
                mem_wr    <= Wr;
                mem_addr  <= Addr;
                mem_wdata <= DataIn;
            end else if (ack_seen) begin
                // Drop the request after exactly one acked cycle so a
                // continuously high mem_ack cannot re-complete it.
                mem_rd    <= 1'b0;
                mem_wr    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                if (mem_rd) begin
                    dout_q <= mem_rdata;
                end
            end
        end
    end

    // Next state and processor-facing handshake outputs.
    always_comb begin
        state_nxt = state;
        Done      = 1'b0;
        Stall     = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        DataOut   = '0;
        case (state)
            IDLE: begin
                if (illegal) begin
                    err  = 1'b1;
                    Done = 1'b1;
                end else if (Rd && hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    DataOut  = hit_data;
                end else if (req) begin
                    Stall     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                Stall = 1'b1;
                if (mem_ack) begin
                    state_nxt = COMPLETE;
                end
            end
            COMPLETE: begin
                // The finished request is still on the bus; ignore it.
                Done      = 1'b1;
                DataOut   = dout_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; expectations adapt to whether the
// cache build option DMEM_CACHE_EN is defined.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Rd, Wr, Done, Stall, CacheHit, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_ack;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef DMEM_CACHE_EN
    localparam logic CE = 1'b1;
`else
    localparam logic CE = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.LINES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .Rd        (Rd),
        .Wr        (Wr),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete request. A hit completes in the request cycle; otherwise
    // mem_ack is given in ACCESS cycle ack_at and Done follows one cycle later.
    task automatic txn(input string nm, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] din,
                       input logic exp_hit, input int ack_at,
                       input logic [15:0] rdata, input logic [15:0] exp_dout);
        step();
        Rd = rd; Wr = wr; Addr = addr; DataIn = din; mem_ack = 1'b0;
        #1;
        chk({nm, "_req_done"},  16'(Done),     16'(exp_hit));
        chk({nm, "_req_hit"},   16'(CacheHit), 16'(exp_hit));
        chk({nm, "_req_stall"}, 16'(Stall),    16'(!exp_hit));
        if (exp_hit) begin
            chk({nm, "_hit_data"}, DataOut, exp_dout);
        end else begin
            for (int i = 1; i <= ack_at; i++) begin
                step();
                if (i == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
                #1;
                chk({nm, "_acc_stall"}, 16'(Stall),  16'h1);
                chk({nm, "_acc_rd"},    16'(mem_rd), 16'(rd));
                chk({nm, "_acc_wr"},    16'(mem_wr), 16'(wr));
                chk({nm, "_acc_addr"},  mem_addr,    addr);
                if (wr) chk({nm, "_acc_wdata"}, mem_wdata, din);
            end
            step();
            mem_ack = 1'b0;
            #1;
            chk({nm, "_cpl_done"},  16'(Done),     16'h1);
            chk({nm, "_cpl_stall"}, 16'(Stall),    16'h0);
            chk({nm, "_cpl_hit"},   16'(CacheHit), 16'h0);
            chk({nm, "_cpl_memrd"}, 16'(mem_rd),   16'h0);
            chk({nm, "_cpl_memwr"}, 16'(mem_wr),   16'h0);
            if (rd) chk({nm, "_cpl_data"}, DataOut, exp_dout);
        end
        step();
        Rd = 1'b0; Wr = 1'b0;
        #1;
        chk({nm, "_idle_done"},  16'(Done),   16'h0);
        chk({nm, "_idle_memrd"}, 16'(mem_rd), 16'h0);
    endtask

    task automatic bad_req(input string nm, input logic rd, input logic wr, input logic [15:0] addr);
        step();
        Rd = rd; Wr = wr; Addr = addr; DataIn = 16'hFFFF;
        #1;
        chk({nm, "_err"},   16'(err),   16'h1);
        chk({nm, "_done"},  16'(Done),  16'h1);
        chk({nm, "_stall"}, 16'(Stall), 16'h0);
        step();
        Rd = 1'b0; Wr = 1'b0;
        #1;
        chk({nm, "_memrd"}, 16'(mem_rd), 16'h0);
        chk({nm, "_memwr"}, 16'(mem_wr), 16'h0);
        chk({nm, "_clr"},   16'(err),    16'h0);
    endtask

    initial begin
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();
        chk("rst_done",  16'(Done),     16'h0);
        chk("rst_stall", 16'(Stall),    16'h0);
        chk("rst_err",   16'(err),      16'h0);
        chk("rst_hit",   16'(CacheHit), 16'h0);
        chk("rst_memrd", 16'(mem_rd),   16'h0);
        chk("rst_memwr", 16'(mem_wr),   16'h0);
        chk("rst_maddr", mem_addr,      16'h0);
        chk("rst_wdata", mem_wdata,     16'h0);
        chk("rst_dout",  DataOut,       16'h0);
        rst = 1'b0;

        // Fill, then hit (cache build) or second miss.
        txn("rd10_miss", 1, 0, 16'h0010, 16'h0, 1'b0, 2, 16'hBEEF, 16'hBEEF);
        txn("rd10_again", 1, 0, 16'h0010, 16'h0, CE, 1, 16'hBEEF, 16'hBEEF);
        // Write-through hit updates the line.
        txn("wr10", 0, 1, 16'h0010, 16'h1234, 1'b0, 2, 16'h0, 16'h0);
        txn("rd10_new", 1, 0, 16'h0010, 16'h0, CE, 1, 16'h1234, 16'h1234);
        // No write-allocate.
        txn("wr40", 0, 1, 16'h0040, 16'h7777, 1'b0, 1, 16'h0, 16'h0);
        txn("rd40", 1, 0, 16'h0040, 16'h0, 1'b0, 1, 16'h7777, 16'h7777);
        // Illegal requests leave the cache alone.
        bad_req("mis_rd", 1, 0, 16'h0011);
        bad_req("rdwr",   1, 1, 16'h0020);
        bad_req("mis_wr", 0, 1, 16'h0013);
        txn("rd10_kept", 1, 0, 16'h0010, 16'h0, CE, 1, 16'h1234, 16'h1234);
        // Conflict on index 1.
        txn("rd02", 1, 0, 16'h0002, 16'h0, 1'b0, 1, 16'h0A0A, 16'h0A0A);
        txn("rd22", 1, 0, 16'h0022, 16'h0, 1'b0, 3, 16'h2222, 16'h2222);
        txn("rd22_hit", 1, 0, 16'h0022, 16'h0, CE, 1, 16'h2222, 16'h2222);
        txn("rd02_evict", 1, 0, 16'h0002, 16'h0, 1'b0, 1, 16'h0A0B, 16'h0A0B);

        // mem_ack held high throughout: ignored in IDLE/COMPLETE.
        step();
        Rd = 1'b1; Addr = 16'h0080; mem_ack = 1'b1; mem_rdata = 16'h4444;
        #1;
        chk("hold_req_stall", 16'(Stall), 16'h1);
        chk("hold_req_done",  16'(Done),  16'h0);
        step();
        chk("hold_acc_memrd", 16'(mem_rd), 16'h1);
        chk("hold_acc_stall", 16'(Stall),  16'h1);
        step();
        chk("hold_cpl_done",  16'(Done),   16'h1);
        chk("hold_cpl_data",  DataOut,     16'h4444);
        chk("hold_cpl_memrd", 16'(mem_rd), 16'h0);
        Rd = 1'b0;
        step();
        chk("hold_idle_done",  16'(Done),   16'h0);
        chk("hold_idle_memrd", 16'(mem_rd), 16'h0);
        chk("hold_idle_stall", 16'(Stall),  16'h0);
        mem_ack = 1'b0;

        // Reset in the middle of ACCESS, with an ack arriving on that edge.
        step();
        Rd = 1'b1; Addr = 16'h0060;
        #1;
        chk("mid_req_stall", 16'(Stall), 16'h1);
        step();
        chk("mid_acc_memrd", 16'(mem_rd), 16'h1);
        rst = 1'b1; Rd = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        rst = 1'b0; mem_ack = 1'b0;
        #1;
        chk("mid_rst_memrd", 16'(mem_rd), 16'h0);
        chk("mid_rst_stall", 16'(Stall),  16'h0);
        chk("mid_rst_done",  16'(Done),   16'h0);
        chk("mid_rst_maddr", mem_addr,    16'h0);
        txn("rd60_after", 1, 0, 16'h0060, 16'h0, 1'b0, 1, 16'h5A5A, 16'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
